// File: rtl/mod_b_dec.sv
// mod_b_dec: inverted-byte decoder feeding a show-ahead FIFO with valid/ready on both sides.
// Optional MOD_B_DEC_STATS_EN adds a saturating 16-bit popped-byte counter on o_bytes.
module mod_b_dec #(
    parameter int DEPTH_LOG2 = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_valid,
    input  logic [7:0]            i_code,
    output logic                  o_ready,
    output logic                  o_valid,
    output logic [7:0]            o_data,
    input  logic                  i_ready,
`ifdef MOD_B_DEC_STATS_EN
    output logic [15:0]           o_bytes,
`endif
    output logic [DEPTH_LOG2:0]   o_level
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    logic [7:0]            mem_q [DEPTH];
    logic [7:0]            mem_d [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   level_q, level_d;
    logic [7:0]            last_q, last_d;
    logic                  push, pop;
    assign o_ready = level_q != (DEPTH_LOG2+1)'(DEPTH);
    assign o_valid = level_q != '0;
    // Empty FIFO keeps showing the most recently popped byte
    assign o_data  = o_valid ? mem_q[rd_ptr_q] : last_q;
    assign o_level = level_q;
    assign push    = i_valid && o_ready;
    assign pop     = o_valid && i_ready;
    always_comb begin
        mem_d = mem_q;
        if (push) mem_d[wr_ptr_q] = ~i_code;
        wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(push);
        rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(pop);
        level_d  = level_q + (DEPTH_LOG2+1)'(push) - (DEPTH_LOG2+1)'(pop);
        last_d   = pop ? mem_q[rd_ptr_q] : last_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            last_q   <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            last_q   <= last_d;
        end
    end
`ifdef MOD_B_DEC_STATS_EN
    logic [15:0] bytes_q, bytes_d;
    assign o_bytes = bytes_q;
    always_comb bytes_d = bytes_q + 16'(pop && bytes_q != 16'hFFFF);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) bytes_q <= '0;
        else     bytes_q <= bytes_d;
    end
`endif
endmodule
